// File: rtl/imem_load_ctrl.sv
// Instruction-RAM port sequencer: boot-loads an image from a host stream, then serves CPU fetch.
// Optional checksum stage enabled by defining IMEM_LOAD_CHECKSUM_EN.
module imem_load_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned NUM_WORDS = 1024,
  parameter int unsigned CNT_W     = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_load_i,
  input  logic [31:0]      load_data_i,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  input  logic [31:0]      fetch_addr_i,
  output logic [31:0]      fetch_instr_o,
  output logic             fetch_valid_o,
  output logic [31:0]      addr_imem_ram_o,
  output logic [31:0]      wr_instr_imem_ram_o,
  output logic             wr_en_imem_ram_o,
  input  logic [31:0]      read_instr_imem_ram_i,
  output logic             cpu_run_o,
  output logic             load_done_o,
  output logic             load_err_o,
  output logic [CNT_W-1:0] words_loaded_o
);

`ifdef IMEM_LOAD_CHECKSUM_EN
  typedef enum logic [2:0] {StIdle, StLoad, StCheck, StRun, StError} state_e;
`else
  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [31:0]      load_addr;
  logic             last_word;

`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
  logic        err_q, err_d;
`endif

  assign load_addr = BASE_ADDR + (32'(cnt_q) << 2);
  assign last_word = (cnt_q == CNT_W'(NUM_WORDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

`ifdef IMEM_LOAD_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      err_q <= err_d;
    end
  end
  assign load_err_o = err_q;
`else
  assign load_err_o = 1'b0;
`endif

  assign load_done_o    = done_q;
  assign words_loaded_o = cnt_q;

  always_comb begin
    state_d             = state_q;
    cnt_d               = cnt_q;
    done_d              = 1'b0;
    load_ready_o        = 1'b0;
    addr_imem_ram_o     = 32'h0;
    wr_instr_imem_ram_o = 32'h0;
    wr_en_imem_ram_o    = 1'b0;
    fetch_instr_o       = 32'h0;
    fetch_valid_o       = 1'b0;
    cpu_run_o           = 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
    sum_d               = sum_q;
    err_d               = err_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start_load_i) begin
          state_d = StLoad;
          cnt_d   = '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      StLoad: begin
        load_ready_o    = 1'b1;
        addr_imem_ram_o = load_addr;
        if (load_valid_i) begin
          wr_en_imem_ram_o    = 1'b1;
          wr_instr_imem_ram_o = load_data_i;
          cnt_d               = cnt_q + CNT_W'(1);
`ifdef IMEM_LOAD_CHECKSUM_EN
          sum_d               = sum_q + load_data_i;
          if (last_word) state_d = StCheck;
`else
          if (last_word) begin
            state_d = StRun;
            done_d  = 1'b1;
          end
`endif
        end
      end
`ifdef IMEM_LOAD_CHECKSUM_EN
      StCheck: begin
        // The word after the image is the expected checksum; it is not written to RAM.
        load_ready_o    = 1'b1;
        addr_imem_ram_o = load_addr;
        if (load_valid_i) begin
          if (load_data_i == sum_q) begin
            state_d = StRun;
            done_d  = 1'b1;
          end else begin
            state_d = StError;
            err_d   = 1'b1;
          end
        end
      end
      StError: begin
        if (start_load_i) begin
          state_d = StLoad;
          cnt_d   = '0;
          sum_d   = '0;
          err_d   = 1'b0;
        end
      end
`endif
      StRun: begin
        cpu_run_o       = 1'b1;
        fetch_valid_o   = 1'b1;
        addr_imem_ram_o = fetch_addr_i & 32'hFFFF_FFFC;
        fetch_instr_o   = read_instr_imem_ram_i;
        if (start_load_i) begin
          state_d = StLoad;
          cnt_d   = '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
          sum_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule
